// File: rtl/cb_hazard_gate.sv
// cb_hazard_gate
//   Admission gate placed in front of a counting bloom filter. It drives the
//   filter's lookup/increment/decrement ports itself. A request is held back
//   while its data may still be in flight: a filter hit, a full filter, or the
//   outstanding limit. Accepted requests go to a registered downstream stage.
//   Retires decrement the filter. A flush waits for all in-flight items to
//   drain, then pulses a filter clear and finally a flush-done pulse.
//
//   Build option: CB_HAZARD_GATE_TIMEOUT_EN adds timeout_o and a stall counter.
//
// Ports
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   req_data_i/valid_i/ready_o    upstream request handshake
//   req_data_o/valid_o/ready_i    downstream registered request handshake
//   ret_data_i/valid_i            retire strobe, no backpressure
//   look_data_o / look_valid_i    filter lookup data / hit
//   incr_data_o/valid_o           filter increment
//   decr_data_o/valid_o           filter decrement
//   filter_full_i                 filter full flag
//   filter_clear_o                filter clear pulse, last step of a flush
//   flush_i / flush_done_o        flush request / completion pulse
//   outstanding_o                 accepted but not yet retired items
//   err_o                         sticky, set by a retire while outstanding==0
//   timeout_o                     (timeout build only) stall timeout pulse
module cb_hazard_gate #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned CntWidth   = 4,
    parameter int unsigned TimeoutCyc = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DataWidth-1:0] req_data_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    output logic [DataWidth-1:0] req_data_o,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    input  logic [DataWidth-1:0] ret_data_i,
    input  logic                 ret_valid_i,
    output logic [DataWidth-1:0] look_data_o,
    input  logic                 look_valid_i,
    output logic [DataWidth-1:0] incr_data_o,
    output logic                 incr_valid_o,
    output logic [DataWidth-1:0] decr_data_o,
    output logic                 decr_valid_o,
    input  logic                 filter_full_i,
    output logic                 filter_clear_o,
    input  logic                 flush_i,
    output logic                 flush_done_o,
    output logic [CntWidth-1:0]  outstanding_o,
`ifdef CB_HAZARD_GATE_TIMEOUT_EN
    output logic                 timeout_o,
`endif
    output logic                 err_o
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // A zero timeout has no meaningful "stalled N cycles" point.
    if (TimeoutCyc < 1) begin : g_bad_cfg
        $error("cb_hazard_gate: TimeoutCyc must be >= 1");
    end

    logic [1:0]           r_state;
    logic [DataWidth-1:0] r_req_data;
    logic                 r_req_valid;
    logic [CntWidth-1:0]  r_cnt;
    logic                 r_err;

    logic w_cnt_max;
    logic w_accept;
    logic w_cnt_zero;

    assign w_cnt_max  = (r_cnt == {CntWidth{1'b1}});
    assign w_cnt_zero = (r_cnt == '0);

    // The lookup is combinational on req_data_i, so ready follows the data.
    assign req_ready_o = (r_state == S_RUN) & !look_valid_i & !filter_full_i & !w_cnt_max
                       & (!r_req_valid | req_ready_i);
    assign w_accept    = req_valid_i & req_ready_o;

    assign look_data_o    = req_data_i;
    assign incr_valid_o   = w_accept;
    assign incr_data_o    = req_data_i;
    assign decr_valid_o   = ret_valid_i;
    assign decr_data_o    = ret_data_i;

    assign req_data_o     = r_req_data;
    assign req_valid_o    = r_req_valid;
    assign outstanding_o  = r_cnt;
    assign err_o          = r_err;
    assign filter_clear_o = (r_state == S_CLEAR);
    assign flush_done_o   = (r_state == S_DONE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= S_RUN;
            r_req_data  <= '0;
            r_req_valid <= 1'b0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
        end else begin
            // Downstream register: a new accept wins over a drain.
            if (w_accept) begin
                r_req_data  <= req_data_i;
                r_req_valid <= 1'b1;
            end else if (req_ready_i) begin
                r_req_valid <= 1'b0;
            end

            // Underflowing retire holds the count at zero and flags the error.
            if (ret_valid_i && !w_accept && w_cnt_zero) begin
                r_err <= 1'b1;
            end

            if (r_state == S_CLEAR) begin
                r_cnt <= '0;
            end else if (w_accept && !ret_valid_i) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (ret_valid_i && !w_accept && !w_cnt_zero) begin
                r_cnt <= r_cnt - 1'b1;
            end

            case (r_state)
                S_RUN:   if (flush_i) r_state <= S_DRAIN;
                S_DRAIN: if (!r_req_valid && w_cnt_zero) r_state <= S_CLEAR;
                S_CLEAR: r_state <= S_DONE;
                default: r_state <= S_RUN;
            endcase
        end
    end

`ifdef CB_HAZARD_GATE_TIMEOUT_EN
    localparam int unsigned SW = $clog2(TimeoutCyc + 1);
    localparam logic [SW-1:0] LP_TO     = SW'(TimeoutCyc);
    localparam logic [SW-1:0] LP_TO_M1  = SW'(TimeoutCyc - 1);

    logic [SW-1:0] r_stall;
    logic          w_stalled;

    assign w_stalled = req_valid_i & !req_ready_o;
    // Fires during the stalled cycle that brings the counter to TimeoutCyc;
    // afterwards the counter saturates so the pulse cannot repeat.
    assign timeout_o = w_stalled & (r_stall == LP_TO_M1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_stall <= '0;
        end else if (!w_stalled) begin
            r_stall <= '0;
        end else if (r_stall != LP_TO) begin
            r_stall <= r_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cb_hazard_gate.sv
module tb_cb_hazard_gate;

    localparam int DW = 8;
    localparam int CW = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [DW-1:0] req_data_i, req_data_o, ret_data_i, look_data_o, incr_data_o, decr_data_o;
    logic          req_valid_i, req_ready_o, req_valid_o, req_ready_i;
    logic          ret_valid_i, look_valid_i, incr_valid_o, decr_valid_o;
    logic          filter_full_i, filter_clear_o, flush_i, flush_done_o, err_o;
    logic [CW-1:0] outstanding_o;
`ifdef CB_HAZARD_GATE_TIMEOUT_EN
    logic          timeout_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    cb_hazard_gate #(.DataWidth(DW), .CntWidth(CW), .TimeoutCyc(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_data_i(req_data_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_data_o(req_data_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .ret_data_i(ret_data_i), .ret_valid_i(ret_valid_i),
        .look_data_o(look_data_o), .look_valid_i(look_valid_i),
        .incr_data_o(incr_data_o), .incr_valid_o(incr_valid_o),
        .decr_data_o(decr_data_o), .decr_valid_o(decr_valid_o),
        .filter_full_i(filter_full_i), .filter_clear_o(filter_clear_o),
        .flush_i(flush_i), .flush_done_o(flush_done_o),
        .outstanding_o(outstanding_o),
`ifdef CB_HAZARD_GATE_TIMEOUT_EN
        .timeout_o(timeout_o),
`endif
        .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic v, input logic [DW-1:0] d);
        req_valid_i = v;
        req_data_i  = d;
        #1;
    endtask

    task automatic ret(input logic v, input logic [DW-1:0] d);
        ret_valid_i = v;
        ret_data_i  = d;
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; req_data_i = '0; req_valid_i = 1'b0; req_ready_i = 1'b1;
        ret_data_i = '0; ret_valid_i = 1'b0; look_valid_i = 1'b0;
        filter_full_i = 1'b0; flush_i = 1'b0;
        tick(); tick();
        chk("rst_vld",   32'(req_valid_o), 0);
        chk("rst_data",  32'(req_data_o), 0);
        chk("rst_cnt",   32'(outstanding_o), 0);
        chk("rst_err",   32'(err_o), 0);
        chk("rst_clr",   32'(filter_clear_o), 0);
        chk("rst_done",  32'(flush_done_o), 0);
        rst_ni = 1'b1;
        tick();

        // Basic accept
        req(1, 8'hA5);
        chk("b_rdy",   32'(req_ready_o), 1);
        chk("b_incv",  32'(incr_valid_o), 1);
        chk("b_incd",  32'(incr_data_o), 32'hA5);
        chk("b_look",  32'(look_data_o), 32'hA5);
        tick(); req(0, 0);
        chk("b_vld",   32'(req_valid_o), 1);
        chk("b_data",  32'(req_data_o), 32'hA5);
        chk("b_cnt",   32'(outstanding_o), 1);
        tick();
        chk("b_vld_clr", 32'(req_valid_o), 0);
        ret(1, 8'hA5);
        chk("r_decv",  32'(decr_valid_o), 1);
        chk("r_decd",  32'(decr_data_o), 32'hA5);
        tick(); ret(0, 0);
        chk("r_cnt",   32'(outstanding_o), 0);

        // Hazard stall on 0x10
        req(1, 8'h10); tick();
        look_valid_i = 1'b1; #1;
        chk("h_rdy0",  32'(req_ready_o), 0);
        chk("h_inc0",  32'(incr_valid_o), 0);
        tick();
        chk("h_rdy1",  32'(req_ready_o), 0);
        chk("h_cnt1",  32'(outstanding_o), 1);
        ret(1, 8'h10);
        chk("h_rdy2",  32'(req_ready_o), 0);
        tick(); ret(0, 0);
        look_valid_i = 1'b0; #1;
        chk("h_rdy3",  32'(req_ready_o), 1);
        tick();
        chk("h_cnt",   32'(outstanding_o), 1);
        chk("h_data",  32'(req_data_o), 32'h10);

        // Downstream backpressure holds data and blocks admission
        req_ready_i = 1'b0;
        req(1, 8'h22);
        chk("bp_rdy",  32'(req_ready_o), 0);
        tick();
        chk("bp_data", 32'(req_data_o), 32'h10);
        req_ready_i = 1'b1; #1;
        chk("bp_rdy1", 32'(req_ready_o), 1);
        tick();
        chk("bp_cnt",  32'(outstanding_o), 2);

        // Outstanding limit (3 with CntWidth=2)
        req(1, 8'h33); tick();
        chk("l_cnt3",  32'(outstanding_o), 3);
        req(1, 8'h44);
        chk("l_rdy0",  32'(req_ready_o), 0);
        ret(1, 8'h10);
        chk("l_rdy1",  32'(req_ready_o), 0);
        tick(); ret(0, 0);
        chk("l_cnt2",  32'(outstanding_o), 2);
        chk("l_rdy2",  32'(req_ready_o), 1);
        tick(); req(0, 0);
        chk("l_cnt",   32'(outstanding_o), 3);
        chk("l_data",  32'(req_data_o), 32'h44);
        ret(1, 8'h22); tick();
        // Accept and retire together leave the count unchanged
        req(1, 8'h55); ret(1, 8'h33);
        chk("s_rdy",   32'(req_ready_o), 1);
        tick(); req(0, 0); ret(0, 0);
        chk("s_cnt",   32'(outstanding_o), 2);
        tick();

        // Flush with 2 outstanding
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        req(1, 8'h66);
        chk("f_rdy",   32'(req_ready_o), 0);
        req(0, 0);
        ret(1, 8'h44); tick();
        chk("f_clr0",  32'(filter_clear_o), 0);
        chk("f_cnt1",  32'(outstanding_o), 1);
        ret(1, 8'h55); tick(); ret(0, 0);
        chk("f_clr1",  32'(filter_clear_o), 0);
        tick();
        chk("f_clr",   32'(filter_clear_o), 1);
        chk("f_done0", 32'(flush_done_o), 0);
        chk("f_cnt0",  32'(outstanding_o), 0);
        tick();
        chk("f_clr_end", 32'(filter_clear_o), 0);
        chk("f_done",  32'(flush_done_o), 1);
        tick();
        chk("f_done_end", 32'(flush_done_o), 0);
        req(1, 8'h77);
        chk("f_run",   32'(req_ready_o), 1);
        req(0, 0);

        // Underflowing retire
        chk("e_pre",   32'(err_o), 0);
        ret(1, 8'h99); tick(); ret(0, 0);
        chk("e_err",   32'(err_o), 1);
        chk("e_cnt",   32'(outstanding_o), 0);
        tick(); tick();
        chk("e_sticky", 32'(err_o), 1);

`ifdef CB_HAZARD_GATE_TIMEOUT_EN
        begin
            int first = 0;
            int pulses = 0;
            filter_full_i = 1'b1;
            req(1, 8'h12);
            for (int c = 1; c <= 12; c++) begin
                if (timeout_o) begin
                    pulses++;
                    if (first == 0) first = c;
                end
                tick();
            end
            chk("t_cycle",  32'(first), 8);
            chk("t_pulses", 32'(pulses), 1);
            filter_full_i = 1'b0;
            req(0, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
